// File: rtl/dexie_cf_buffer.sv
// Control-flow event buffer between the branch unit's DExIE outputs and the external monitor.
// FWFT circular FIFO with optional sequential-event filter, early stall request and drop accounting.
module dexie_cf_buffer #(
  parameter int DEPTH              = 8,
  parameter int ALMOST_FULL_MARGIN = 2,
  parameter int FILTER_SEQUENTIAL  = 1,
  parameter int DROP_COUNT_W       = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cf_valid,
  input  logic [31:0]                cf_cur_pc,
  input  logic [31:0]                cf_cur_instruction,
  input  logic [31:0]                cf_next_pc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_cur_pc,
  output logic [31:0]                out_instruction,
  output logic [31:0]                out_next_pc,
  output logic [$clog2(DEPTH):0]     occupancy,
  output logic                       stall_request,
  output logic                       overflow,
  input  logic                       clear_overflow,
  output logic [DROP_COUNT_W-1:0]    drop_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;

  typedef struct packed {
    logic [31:0] cur_pc;
    logic [31:0] instruction;
    logic [31:0] next_pc;
  } entry_t;

  entry_t                  mem [DEPTH];
  logic [PTR_W-1:0]        rd_ptr;
  logic [PTR_W-1:0]        wr_ptr;
  logic [OCC_W-1:0]        occ;
  logic                    overflow_q;
  logic [DROP_COUNT_W-1:0] drop_q;

  logic filtered;
  logic accept;
  logic full;
  logic pop;
  logic push;
  logic drop;

  function automatic logic is_cf_opcode(input logic [6:0] op);
    return (op == 7'b1101111) || (op == 7'b1100111) || (op == 7'b1100011);
  endfunction

  function automatic logic [DROP_COUNT_W-1:0] sat_inc(input logic [DROP_COUNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_comb begin
    filtered = 1'b0;
    if (FILTER_SEQUENTIAL != 0)
      filtered = (cf_next_pc == cf_cur_pc + 32'd4) && !is_cf_opcode(cf_cur_instruction[6:0]);
    accept = cf_valid & ~filtered;
    full   = (occ == OCC_W'(DEPTH));
    pop    = out_valid & out_ready;
    push   = accept & (~full | pop);
    drop   = accept & full & ~pop;
  end

  // Control state: pointers, occupancy and drop accounting
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      occ        <= '0;
      overflow_q <= 1'b0;
      drop_q     <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      occ <= occ + 1'b1;
      else if (pop && !push) occ <= occ - 1'b1;
      // A drop in the same cycle as a clear restarts the count at one
      if (drop) begin
        overflow_q <= 1'b1;
        drop_q     <= clear_overflow ? DROP_COUNT_W'(1) : sat_inc(drop_q);
      end else if (clear_overflow) begin
        overflow_q <= 1'b0;
        drop_q     <= '0;
      end
    end
  end

  // Payload storage carries no reset; emptiness is masked at the output
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{cur_pc: cf_cur_pc, instruction: cf_cur_instruction, next_pc: cf_next_pc};
  end

  always_comb begin
    out_valid       = (occ != '0);
    out_cur_pc      = out_valid ? mem[rd_ptr].cur_pc      : 32'd0;
    out_instruction = out_valid ? mem[rd_ptr].instruction : 32'd0;
    out_next_pc     = out_valid ? mem[rd_ptr].next_pc     : 32'd0;
    occupancy       = occ;
    stall_request   = (occ >= OCC_W'(DEPTH - ALMOST_FULL_MARGIN));
    overflow        = overflow_q;
    drop_count      = drop_q;
  end

endmodule

// File: tb/tb_dexie_cf_buffer.sv
// Bench for dexie_cf_buffer: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_dexie_cf_buffer;
  localparam int DEPTH  = 8;
  localparam int MARGIN = 2;
  localparam int DCW    = 4;
  localparam int DMAX   = (1 << DCW) - 1;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cf_valid = 1'b0;
  logic [31:0] cf_cur_pc = '0, cf_cur_instruction = '0, cf_next_pc = '0;
  logic        out_valid, out_ready = 1'b0;
  logic [31:0] out_cur_pc, out_instruction, out_next_pc;
  logic [$clog2(DEPTH):0] occupancy;
  logic        stall_request, overflow;
  logic        clear_overflow = 1'b0;
  logic [DCW-1:0] drop_count;

  dexie_cf_buffer #(.DEPTH(DEPTH), .ALMOST_FULL_MARGIN(MARGIN), .FILTER_SEQUENTIAL(1),
                    .DROP_COUNT_W(DCW)) dut (
    .clk(clk), .rst(rst), .cf_valid(cf_valid), .cf_cur_pc(cf_cur_pc),
    .cf_cur_instruction(cf_cur_instruction), .cf_next_pc(cf_next_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_cur_pc(out_cur_pc),
    .out_instruction(out_instruction), .out_next_pc(out_next_pc),
    .occupancy(occupancy), .stall_request(stall_request), .overflow(overflow),
    .clear_overflow(clear_overflow), .drop_count(drop_count));

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  bit started = 0;

  // Reference model: a queue of {pc, instr, next} plus overflow flag and drop counter
  logic [95:0] q[$];
  bit m_ovf = 0;
  int m_dc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit is_cf(input logic [31:0] instr);
    return instr[6:0] == 7'h6F || instr[6:0] == 7'h67 || instr[6:0] == 7'h63;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      m_ovf = 0;
      m_dc = 0;
      started = 1;
    end else begin
      bit acc, pp, dr;
      acc = cf_valid && !(cf_next_pc == cf_cur_pc + 32'd4 && !is_cf(cf_cur_instruction));
      pp  = (q.size() > 0) && out_ready;
      dr  = acc && q.size() == DEPTH && !pp;
      if (pp) void'(q.pop_front());
      if (acc && !dr) q.push_back({cf_cur_pc, cf_cur_instruction, cf_next_pc});
      if (dr) begin
        m_ovf = 1;
        m_dc = clear_overflow ? 1 : (m_dc == DMAX ? DMAX : m_dc + 1);
      end else if (clear_overflow) begin
        m_ovf = 0;
        m_dc = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      logic [95:0] h;
      h = (q.size() > 0) ? q[0] : 96'd0;
      chk("m_out_valid", 32'(out_valid), 32'(q.size() > 0));
      chk("m_out_cur_pc", out_cur_pc, h[95:64]);
      chk("m_out_instruction", out_instruction, h[63:32]);
      chk("m_out_next_pc", out_next_pc, h[31:0]);
      chk("m_occupancy", 32'(occupancy), 32'(q.size()));
      chk("m_stall_request", 32'(stall_request), 32'(q.size() >= DEPTH - MARGIN));
      chk("m_overflow", 32'(overflow), 32'(m_ovf));
      chk("m_drop_count", 32'(drop_count), 32'(m_dc));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic ev(input logic [31:0] pc, input logic [31:0] instr, input logic [31:0] nxt);
    cf_valid = 1'b1;
    cf_cur_pc = pc;
    cf_cur_instruction = instr;
    cf_next_pc = nxt;
    cyc();
    cf_valid = 1'b0;
  endtask

  task automatic drain(input int n);
    out_ready = 1'b1;
    repeat (n) cyc();
    out_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] pc;
    #2;
    rst = 1'b1;
    repeat (2) cyc();
    rst = 1'b0;
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_occupancy", 32'(occupancy), 32'd0);
    chk("reset_stall", 32'(stall_request), 32'd0);
    chk("reset_overflow", 32'(overflow), 32'd0);
    chk("reset_drop_count", 32'(drop_count), 32'd0);
    chk("reset_out_cur_pc", out_cur_pc, 32'd0);

    // Single JAL event, one cycle latency, then pop
    ev(32'h100, 32'h0080006F, 32'h108);
    chk("jal_out_valid", 32'(out_valid), 32'd1);
    chk("jal_pc", out_cur_pc, 32'h100);
    chk("jal_instr", out_instruction, 32'h0080006F);
    chk("jal_next", out_next_pc, 32'h108);
    chk("jal_occ", 32'(occupancy), 32'd1);
    drain(1);
    chk("jal_popped_valid", 32'(out_valid), 32'd0);
    chk("jal_popped_occ", 32'(occupancy), 32'd0);

    // Sequential ADDI filtered, redirected ADDI kept
    ev(32'h200, 32'h00100093, 32'h204);
    chk("addi_seq_occ", 32'(occupancy), 32'd0);
    chk("addi_seq_drops", 32'(drop_count), 32'd0);
    ev(32'h200, 32'h00100093, 32'h300);
    chk("addi_redir_occ", 32'(occupancy), 32'd1);
    chk("addi_redir_next", out_next_pc, 32'h300);
    drain(1);

    // Fill with branches: stall after 6th, overflow after 8
    pc = 32'h1000;
    for (int i = 0; i < 6; i++) begin
      ev(pc, 32'h00000063, pc + 4);
      pc += 4;
      if (i == 4) chk("stall_at_5", 32'(stall_request), 32'd0);
    end
    chk("stall_at_6", 32'(stall_request), 32'd1);
    chk("occ_at_6", 32'(occupancy), 32'd6);
    for (int i = 0; i < 5; i++) begin
      ev(pc, 32'h00000063, pc + 4);
      pc += 4;
    end
    chk("full_occ", 32'(occupancy), 32'd8);
    chk("ovf_after_3", 32'(overflow), 32'd1);
    chk("drops_3", 32'(drop_count), 32'd3);
    chk("head_still_first", out_cur_pc, 32'h1000);

    // Push and pop together while full
    out_ready = 1'b1;
    ev(32'h2000, 32'h00000063, 32'h2004);
    out_ready = 1'b0;
    chk("pushpop_occ", 32'(occupancy), 32'd8);
    chk("pushpop_drops", 32'(drop_count), 32'd3);
    chk("pushpop_head", out_cur_pc, 32'h1004);

    // Drop coinciding with clear
    ev(32'h3000, 32'h00000063, 32'h3004);
    ev(32'h3004, 32'h00000063, 32'h3008);
    chk("drops_5", 32'(drop_count), 32'd5);
    clear_overflow = 1'b1;
    ev(32'h3008, 32'h00000063, 32'h300C);
    chk("drop_clear_ovf", 32'(overflow), 32'd1);
    chk("drop_clear_cnt", 32'(drop_count), 32'd1);
    cyc();
    clear_overflow = 1'b0;
    chk("clear_ovf", 32'(overflow), 32'd0);
    chk("clear_cnt", 32'(drop_count), 32'd0);
    drain(7);
    chk("last_head", out_cur_pc, 32'h2000);
    drain(1);
    chk("drained_occ", 32'(occupancy), 32'd0);

    // Drop counter saturation
    for (int i = 0; i < DEPTH + DMAX + 4; i++) ev(32'h4000 + 32'(i) * 8, 32'h0000006F, 32'h5000);
    chk("sat_drop_count", 32'(drop_count), 32'(DMAX));
    clear_overflow = 1'b1;
    drain(DEPTH);
    clear_overflow = 1'b0;

    // Mid-stream reset with 4 buffered entries
    for (int i = 0; i < 4; i++) ev(32'h600 + 32'(i) * 4, 32'h00000063, 32'h700);
    chk("pre_rst_occ", 32'(occupancy), 32'd4);
    rst = 1'b1;
    ev(32'h900, 32'h0000006F, 32'h904);
    rst = 1'b0;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_occ", 32'(occupancy), 32'd0);
    ev(32'h500, 32'h00000067, 32'h800);
    chk("post_rst_pc", out_cur_pc, 32'h500);
    chk("post_rst_instr", out_instruction, 32'h00000067);
    drain(1);

    // Randomized traffic
    for (int n = 0; n < 4000; n++) begin
      logic [31:0] rpc;
      logic [6:0] op;
      rpc = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 99) == 0) rpc = 32'hFFFF_FFFC;
      case ($urandom_range(0, 4))
        0: op = 7'h6F;
        1: op = 7'h67;
        2: op = 7'h63;
        default: op = 7'h13;
      endcase
      cf_cur_pc = rpc;
      cf_cur_instruction = {$urandom_range(0, 32'h01FF_FFFF), op};
      cf_next_pc = ($urandom_range(0, 2) != 0) ? rpc + 32'd4 : $urandom;
      cf_valid = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < ((n / 500) % 2 == 0 ? 3 : 7));
      clear_overflow = ($urandom_range(0, 39) == 0);
      rst = ($urandom_range(0, 299) == 0);
      cyc();
    end
    cf_valid = 1'b0;
    rst = 1'b0;
    clear_overflow = 1'b0;
    drain(DEPTH + 1);
    chk("final_occ", 32'(occupancy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
